// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word fetches on a single-outstanding bus and
// holds one fetched instruction for if_id, with branch redirect and flush handling.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_from_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic        buf_valid;
    logic [31:0] fetch_pc;
    logic        redir_pending;
    logic [31:0] redir_pc;

    logic        consume;
    logic        buf_free;
    logic        branch_take;
    logic [31:0] issue_addr;
    logic        unused_stall;

    assign unused_stall = ^stall[5:3];

    always_comb begin
        consume     = buf_valid & ~stall[1];
        buf_free    = ~buf_valid | consume;
        branch_take = ~stall[2] & branch_flag_i;
        issue_addr  = redir_pending ? redir_pc : fetch_pc;
        issue_addr  = {issue_addr[31:2], 2'b00};
    end

    assign stallreq_from_if = ~buf_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            ibus_req      <= 1'b0;
            ibus_addr     <= 32'h0;
            buf_valid     <= 1'b0;
            if_pc         <= 32'h0;
            if_inst       <= 32'h0;
            fetch_pc      <= RESET_PC;
            redir_pending <= 1'b0;
            redir_pc      <= 32'h0;
        end else if (flush) begin
            // Flush drops the buffer and any redirect; an unacked request must
            // still run to completion on the bus, so its data is discarded later.
            buf_valid     <= 1'b0;
            redir_pending <= 1'b0;
            fetch_pc      <= new_pc;
            case (state)
                WAIT: begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: ;
            endcase
        end else begin
            if (consume)
                buf_valid <= 1'b0;
            if (branch_take) begin
                redir_pending <= 1'b1;
                redir_pc      <= branch_target_address_i;
            end
            case (state)
                IDLE: begin
                    if (!stall[0] && buf_free) begin
                        ibus_req  <= 1'b1;
                        ibus_addr <= issue_addr;
                        fetch_pc  <= issue_addr + 32'd4;
                        state     <= WAIT;
                        // A branch captured on this same edge is a fresh redirect.
                        if (redir_pending && !branch_take)
                            redir_pending <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ibus_ack) begin
                        if_pc     <= ibus_addr;
                        if_inst   <= ibus_rdata;
                        buf_valid <= 1'b1;
                        ibus_req  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DISCARD: begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed boot/wait/flush/reset steps, then random traffic
// checked each cycle against a transaction-level reference model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_from_if;

    int vectors = 0;
    int errs    = 0;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ibus_req                (ibus_req),
        .ibus_addr               (ibus_addr),
        .ibus_ack                (ibus_ack),
        .ibus_rdata              (ibus_rdata),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_from_if        (stallreq_from_if)
    );

    always #5 clk = ~clk;

    // Reference model: one optional outstanding bus transaction (with a drop
    // flag), a one-entry instruction buffer, the sequential pc and a redirect.
    logic        m_req, m_drop, m_bv, m_rp;
    logic [31:0] m_addr, m_pc, m_inst, m_fpc, m_rpc;

    task automatic model_step();
        logic        n_req, n_drop, n_bv, n_rp;
        logic [31:0] n_addr, n_pc, n_inst, n_fpc, n_rpc, a;
        n_req = m_req; n_drop = m_drop; n_bv = m_bv; n_rp = m_rp;
        n_addr = m_addr; n_pc = m_pc; n_inst = m_inst; n_fpc = m_fpc; n_rpc = m_rpc;
        if (!rst) begin
            n_req = 0; n_drop = 0; n_bv = 0; n_rp = 0;
            n_addr = 0; n_pc = 0; n_inst = 0; n_fpc = RESET_PC; n_rpc = 0;
        end else if (flush) begin
            n_bv = 0; n_rp = 0; n_fpc = new_pc;
            if (m_req && ibus_ack) begin
                n_req = 0; n_drop = 0;
            end else if (m_req) begin
                n_drop = 1;
            end
        end else begin
            if (m_bv && !stall[1]) n_bv = 0;
            if (m_req && ibus_ack) begin
                n_req = 0;
                if (!m_drop) begin
                    n_bv = 1; n_pc = m_addr; n_inst = ibus_rdata;
                end
                n_drop = 0;
            end else if (!m_req && !stall[0] && (!m_bv || !stall[1])) begin
                a = m_rp ? m_rpc : m_fpc;
                a[1:0] = 2'b00;
                n_req = 1; n_addr = a; n_fpc = a + 32'd4; n_rp = 0;
            end
            if (!stall[2] && branch_flag_i) begin
                n_rp = 1; n_rpc = branch_target_address_i;
            end
        end
        m_req = n_req; m_drop = n_drop; m_bv = n_bv; m_rp = n_rp;
        m_addr = n_addr; m_pc = n_pc; m_inst = n_inst; m_fpc = n_fpc; m_rpc = n_rpc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model advances on the pre-edge inputs, outputs checked #1 later.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("ibus_req", {31'b0, ibus_req}, {31'b0, m_req});
        if (m_req) chk("ibus_addr", ibus_addr, m_addr);
        chk("if_pc", if_pc, m_pc);
        chk("if_inst", if_inst, m_inst);
        chk("stallreq", {31'b0, stallreq_from_if}, {31'b0, !m_bv});
    endtask

    task automatic idle_inputs();
        stall = 6'b0; flush = 0; new_pc = 0; branch_flag_i = 0;
        branch_target_address_i = 0; ibus_ack = 0; ibus_rdata = 0;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        #1;
        // Reset state
        cyc();
        cyc();
        chk("rst_req", {31'b0, ibus_req}, 32'd0);
        chk("rst_stallreq", {31'b0, stallreq_from_if}, 32'd1);
        chk("rst_if_pc", if_pc, 32'd0);

        // Boot: first fetch at RESET_PC, 1-cycle ack
        rst = 1;
        cyc();
        chk("boot_addr", ibus_addr, 32'h0);
        chk("boot_req", {31'b0, ibus_req}, 32'd1);
        ibus_ack = 1; ibus_rdata = 32'h3C01_0001;
        cyc();
        chk("boot_inst", if_inst, 32'h3C01_0001);
        chk("boot_pc", if_pc, 32'h0);
        chk("boot_stallreq", {31'b0, stallreq_from_if}, 32'd0);
        ibus_ack = 0;
        cyc();
        chk("next_addr", ibus_addr, 32'h4);

        // Wait states: request for 0x4 stays up while ack is withheld
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ws_req", {31'b0, ibus_req}, 32'd1);
            chk("ws_addr", ibus_addr, 32'h4);
            chk("ws_stallreq", {31'b0, stallreq_from_if}, 32'd1);
        end
        ibus_ack = 1; ibus_rdata = 32'h2000_0004;
        cyc();
        chk("ws_fill_pc", if_pc, 32'h4);
        chk("ws_fill_inst", if_inst, 32'h2000_0004);

        // Flush from IDLE to top of address space, then wrap to 0
        ibus_ack = 0; flush = 1; new_pc = 32'hFFFF_FFFC;
        stall = 6'b000010;
        cyc();
        chk("flush_noissue", {31'b0, ibus_req}, 32'd0);
        chk("flush_bufclr", {31'b0, stallreq_from_if}, 32'd1);
        flush = 0; stall = 0;
        cyc();
        chk("wrap_hi_addr", ibus_addr, 32'hFFFF_FFFC);
        ibus_ack = 1; ibus_rdata = 32'h1111_1111;
        cyc();
        chk("wrap_hi_pc", if_pc, 32'hFFFF_FFFC);
        ibus_ack = 0;
        cyc();
        chk("wrap_lo_addr", ibus_addr, 32'h0);

        // Flush while request outstanding: data discarded, then 0x180
        flush = 1; new_pc = 32'h180;
        cyc();
        chk("disc_req_held", {31'b0, ibus_req}, 32'd1);
        flush = 0; ibus_ack = 1; ibus_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("disc_req_drop", {31'b0, ibus_req}, 32'd0);
        chk("disc_nodeliver", {31'b0, stallreq_from_if}, 32'd1);
        ibus_ack = 0;
        cyc();
        chk("post_flush_addr", ibus_addr, 32'h180);
        ibus_ack = 1; ibus_rdata = 32'h0180_0180;
        cyc();
        ibus_ack = 0;
        cyc();
        chk("seq_addr", ibus_addr, 32'h184);

        // Reset mid-WAIT, then a late ack must be ignored
        rst = 0;
        cyc();
        chk("rstw_req", {31'b0, ibus_req}, 32'd0);
        rst = 1; ibus_ack = 1; ibus_rdata = 32'h5555_5555;
        cyc();
        chk("rstw_addr", ibus_addr, RESET_PC);
        chk("rstw_nofill", {31'b0, stallreq_from_if}, 32'd1);
        ibus_ack = 0;
        cyc();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst                     = ($urandom_range(0, 199) != 0);
            stall                   = 6'b0;
            stall[0]                = ($urandom_range(0, 5) == 0);
            stall[1]                = ($urandom_range(0, 3) == 0);
            stall[2]                = ($urandom_range(0, 3) == 0);
            stall[5:3]              = 3'($urandom);
            flush                   = ($urandom_range(0, 19) == 0);
            new_pc                  = {$urandom_range(0, 255), 2'b00};
            branch_flag_i           = ($urandom_range(0, 6) == 0);
            branch_target_address_i = {$urandom_range(0, 1023), 2'b00};
            ibus_ack                = m_req ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 9) == 0);
            ibus_rdata              = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
